// File: rtl/mem_llsc_ctrl.sv
// rtl/mem_llsc_ctrl.sv - memory access controller with LL/SC support and bus timeout
module mem_llsc_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        Rst_n,
   input  logic        flush,
   input  logic [2:0]  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  wd_i,
   input  logic        LLbit_i,
   input  logic        wb_LLbit_we_i,
   input  logic        wb_LLbit_value_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        stall_o,
   output logic        wreg_o,
   output logic [4:0]  wd_o,
   output logic [31:0] wdata_o,
   output logic        LLbit_we_o,
   output logic        LLbit_value_o,
   output logic [1:0]  excep_o
);

   localparam logic [2:0] OP_LW = 3'b001;
   localparam logic [2:0] OP_SW = 3'b010;
   localparam logic [2:0] OP_LL = 3'b011;
   localparam logic [2:0] OP_SC = 3'b100;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  op_q;
   logic [4:0]  wd_q;
   logic        bus_req_q, bus_we_q, wreg_q, llbit_we_q, llbit_val_q;
   logic [31:0] bus_addr_q, bus_wdata_q, wdata_q;
   logic [4:0]  wd_out_q;
   logic [1:0]  excep_q;

   logic llbit_eff_d, op_valid_d, aligned_d;

   // The write-back stage may be updating LLbit in this very cycle.
   assign llbit_eff_d = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
   assign op_valid_d  = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_LL) || (op_i == OP_SC);
   assign aligned_d   = (addr_i[1:0] == 2'b00);

   assign stall_o = Rst_n && (((state_q == IDLE) && op_valid_d && aligned_d) || (state_q == BUSY));

   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         wd_q        <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         wreg_q      <= 1'b0;
         wd_out_q    <= '0;
         wdata_q     <= '0;
         llbit_we_q  <= 1'b0;
         llbit_val_q <= 1'b0;
         excep_q     <= 2'b00;
      end else begin
         // Result outputs are single-cycle pulses unless set below.
         wreg_q      <= 1'b0;
         wd_out_q    <= '0;
         wdata_q     <= '0;
         llbit_we_q  <= 1'b0;
         llbit_val_q <= 1'b0;
         excep_q     <= 2'b00;
         if (flush) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (op_valid_d) begin
                     if (!aligned_d) begin
                        excep_q <= 2'b01;
                     end else if ((op_i == OP_SC) && !llbit_eff_d) begin
                        state_q  <= DONE;
                        wreg_q   <= 1'b1;
                        wd_out_q <= wd_i;
                     end else begin
                        state_q     <= BUSY;
                        cnt_q       <= '0;
                        op_q        <= op_i;
                        wd_q        <= wd_i;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= (op_i == OP_SW) || (op_i == OP_SC);
                        bus_addr_q  <= addr_i;
                        bus_wdata_q <= wdata_i;
                     end
                  end
               end
               BUSY: begin
                  if (bus_ack_i) begin
                     state_q   <= DONE;
                     bus_req_q <= 1'b0;
                     bus_we_q  <= 1'b0;
                     wd_out_q  <= wd_q;
                     case (op_q)
                        OP_LW: begin
                           wreg_q  <= 1'b1;
                           wdata_q <= bus_rdata_i;
                        end
                        OP_LL: begin
                           wreg_q      <= 1'b1;
                           wdata_q     <= bus_rdata_i;
                           llbit_we_q  <= 1'b1;
                           llbit_val_q <= 1'b1;
                        end
                        OP_SC: begin
                           wreg_q     <= 1'b1;
                           wdata_q    <= 32'd1;
                           llbit_we_q <= 1'b1;
                        end
                        default: ;
                     endcase
                  end else if (cnt_q == TO_LAST) begin
                     state_q   <= IDLE;
                     bus_req_q <= 1'b0;
                     bus_we_q  <= 1'b0;
                     excep_q   <= 2'b10;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus_req_o     = bus_req_q;
   assign bus_we_o      = bus_we_q;
   assign bus_addr_o    = bus_addr_q;
   assign bus_wdata_o   = bus_wdata_q;
   assign wreg_o        = wreg_q;
   assign wd_o          = wd_out_q;
   assign wdata_o       = wdata_q;
   assign LLbit_we_o    = llbit_we_q;
   assign LLbit_value_o = llbit_val_q;
   assign excep_o       = excep_q;

endmodule

// File: tb/tb_mem_llsc_ctrl.sv
// tb/tb_mem_llsc_ctrl.sv - directed scoreboard bench for mem_llsc_ctrl
module tb_mem_llsc_ctrl;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_LW   = 3'b001;
   localparam logic [2:0] OP_SW   = 3'b010;
   localparam logic [2:0] OP_LL   = 3'b011;
   localparam logic [2:0] OP_SC   = 3'b100;

   typedef struct packed {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        llwe;
      logic        llval;
      logic [1:0]  exc;
   } exp_t;

   logic        clk = 1'b0;
   logic        Rst_n, flush;
   logic [2:0]  op_i;
   logic [31:0] addr_i, wdata_i, bus_rdata_i, bus_addr_o, bus_wdata_o, wdata_o;
   logic [4:0]  wd_i, wd_o;
   logic        LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i, bus_ack_i;
   logic        bus_req_o, bus_we_o, stall_o, wreg_o, LLbit_we_o, LLbit_value_o;
   logic [1:0]  excep_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   int          nreq, pulses;
   logic        we_seen, istall, bstall;
   logic [31:0] baddr, bwdata;

   always #5 clk = ~clk;

   mem_llsc_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .Rst_n(Rst_n), .flush(flush), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .wd_i(wd_i), .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i),
      .wb_LLbit_value_i(wb_LLbit_value_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
      .bus_ack_i(bus_ack_i), .stall_o(stall_o), .wreg_o(wreg_o), .wd_o(wd_o),
      .wdata_o(wdata_o), .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
      .excep_o(excep_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr, input logic llbit_eff,
                                  input logic [31:0] rdata, input logic [4:0] wd, input bit acked);
      exp_t e;
      e = '0;
      if (addr[1:0] != 2'b00) e.exc = 2'b01;
      else if (op == OP_SC && !llbit_eff) begin
         e.wreg = 1'b1;
         e.wd   = wd;
      end else if (!acked) e.exc = 2'b10;
      else begin
         e.wd = wd;
         case (op)
            OP_LW: begin e.wreg = 1'b1; e.wdata = rdata; end
            OP_LL: begin e.wreg = 1'b1; e.wdata = rdata; e.llwe = 1'b1; e.llval = 1'b1; end
            OP_SC: begin e.wreg = 1'b1; e.wdata = 32'd1; e.llwe = 1'b1; end
            default: ;
         endcase
      end
      return e;
   endfunction

   function automatic logic eff_llbit();
      return wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
   endfunction

   // Issues one access, acks on BUSY cycle ack_at (0 = never); returns with the DUT just past BUSY.
   task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] wd, input int ack_at, input logic [31:0] rdata,
                         output int nr, output logic we, output logic [31:0] ba,
                         output logic [31:0] bw, output logic ist, output logic bst);
      op_i = op; addr_i = addr; wdata_i = wdata; wd_i = wd;
      #1;
      ist = stall_o;
      nr = 0; we = 1'b0; ba = '0; bw = '0; bst = 1'b1;
      step();
      op_i = OP_NONE;
      #1;
      for (int k = 1; k <= 40; k++) begin
         if (!bus_req_o) break;
         if (k == 1) begin ba = bus_addr_o; bw = bus_wdata_o; end
         nr++;
         we  = we | bus_we_o;
         bst = bst & stall_o;
         if (k == ack_at) begin bus_ack_i = 1'b1; bus_rdata_i = rdata; end
         step();
         bus_ack_i = 1'b0;
         #1;
      end
   endtask

   task automatic wait_result(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (!(wreg_o || LLbit_we_o || excep_o != 2'b00 || wd_o != 5'd0) && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_seen"}, 32'(n < 20), 32'd1);
      e = sb.pop_front();
      chk({tag, "_wreg"},  32'(wreg_o), 32'(e.wreg));
      chk({tag, "_wd"},    32'(wd_o), 32'(e.wd));
      chk({tag, "_wdata"}, wdata_o, e.wdata);
      chk({tag, "_llwe"},  32'(LLbit_we_o), 32'(e.llwe));
      if (e.llwe) chk({tag, "_llval"}, 32'(LLbit_value_o), 32'(e.llval));
      chk({tag, "_exc"},   32'(excep_o), 32'(e.exc));
      chk({tag, "_stall"}, 32'(stall_o), 32'd0);
      step();
      #1;
      chk({tag, "_pulse"}, 32'({wreg_o, LLbit_we_o, excep_o}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n = 1'b0; flush = 1'b0; op_i = OP_LW; addr_i = 32'h100; wdata_i = '0; wd_i = 5'd1;
      LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
      bus_rdata_i = 32'h1111; bus_ack_i = 1'b1;
      step(); step(); #1;
      chk("rst_stall",  32'(stall_o), 32'd0);
      chk("rst_outs",   32'({bus_req_o, bus_we_o, wreg_o, LLbit_we_o, LLbit_value_o, excep_o}), 32'd0);
      chk("rst_wd",     32'(wd_o), 32'd0);
      chk("rst_wdata",  wdata_o, 32'd0);
      op_i = OP_NONE; bus_ack_i = 1'b0; Rst_n = 1'b1;
      step();

      bus_ack_i = 1'b1; bus_rdata_i = 32'h99;
      step(); step();
      bus_ack_i = 1'b0;
      #1;
      chk("idle_ack_ignored", 32'({bus_req_o, wreg_o, LLbit_we_o}), 32'd0);

      sb.push_back(model(OP_LW, 32'h100, eff_llbit(), 32'hDEADBEEF, 5'd3, 1));
      run_op(OP_LW, 32'h100, 32'h0, 5'd3, 3, 32'hDEADBEEF, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("lw_nreq", 32'(nreq), 32'd3);
      chk("lw_addr", baddr, 32'h100);
      chk("lw_we", 32'(we_seen), 32'd0);
      chk("lw_istall", 32'(istall), 32'd1);
      chk("lw_bstall", 32'(bstall), 32'd1);
      wait_result("lw");

      sb.push_back(model(OP_LL, 32'h200, eff_llbit(), 32'h0000_1234, 5'd4, 1));
      run_op(OP_LL, 32'h200, 32'h0, 5'd4, 2, 32'h0000_1234, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("ll_nreq", 32'(nreq), 32'd2);
      wait_result("ll");

      LLbit_i = 1'b1;
      sb.push_back(model(OP_SC, 32'h200, eff_llbit(), 32'h0, 5'd5, 1));
      run_op(OP_SC, 32'h200, 32'h55, 5'd5, 1, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("sc_nreq", 32'(nreq), 32'd1);
      chk("sc_we", 32'(we_seen), 32'd1);
      chk("sc_bwdata", bwdata, 32'h55);
      wait_result("sc");

      wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
      sb.push_back(model(OP_SC, 32'h200, eff_llbit(), 32'h0, 5'd6, 1));
      run_op(OP_SC, 32'h200, 32'h55, 5'd6, 1, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("scfail_nreq", 32'(nreq), 32'd0);
      chk("scfail_istall", 32'(istall), 32'd1);
      wait_result("scfail");

      LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
      sb.push_back(model(OP_SC, 32'h204, eff_llbit(), 32'h0, 5'd8, 1));
      run_op(OP_SC, 32'h204, 32'hAA, 5'd8, 2, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("scfwd_nreq", 32'(nreq), 32'd2);
      wait_result("scfwd");
      wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;

      sb.push_back(model(OP_SW, 32'h102, eff_llbit(), 32'h0, 5'd7, 1));
      run_op(OP_SW, 32'h102, 32'h1234, 5'd7, 1, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("swmis_nreq", 32'(nreq), 32'd0);
      chk("swmis_istall", 32'(istall), 32'd0);
      wait_result("swmis");

      sb.push_back(model(OP_SW, 32'h104, eff_llbit(), 32'h0, 5'd7, 1));
      run_op(OP_SW, 32'h104, 32'hCAFE, 5'd7, 2, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("sw_nreq", 32'(nreq), 32'd2);
      chk("sw_we", 32'(we_seen), 32'd1);
      chk("sw_bwdata", bwdata, 32'hCAFE);
      wait_result("sw");

      sb.push_back(model(OP_LW, 32'h108, eff_llbit(), 32'h0, 5'd2, 0));
      run_op(OP_LW, 32'h108, 32'h0, 5'd2, 0, 32'h0, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("to_nreq", 32'(nreq), 32'd16);
      chk("to_bstall", 32'(bstall), 32'd1);
      wait_result("to");

      for (int v = 0; v < 2; v++) begin
         op_i = OP_LL; addr_i = 32'h300; wd_i = 5'd9;
         step();
         op_i = OP_NONE;
         step();
         bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD; flush = 1'b1;
         if (v == 1) Rst_n = 1'b0;
         step();
         bus_ack_i = 1'b0; flush = 1'b0; Rst_n = 1'b1;
         #1;
         chk(v == 0 ? "flush_req" : "rst_req", 32'(bus_req_o), 32'd0);
         chk(v == 0 ? "flush_stall" : "rst_stall2", 32'(stall_o), 32'd0);
         pulses = 0;
         for (int c = 0; c < 4; c++) begin
            if (wreg_o || LLbit_we_o || excep_o != 2'b00) pulses++;
            step();
         end
         chk(v == 0 ? "flush_pulses" : "rst_pulses", 32'(pulses), 32'd0);
      end

      sb.push_back(model(OP_LW, 32'h400, eff_llbit(), 32'h77, 5'd10, 1));
      run_op(OP_LW, 32'h400, 32'h0, 5'd10, 1, 32'h77, nreq, we_seen, baddr, bwdata, istall, bstall);
      chk("rec_nreq", 32'(nreq), 32'd1);
      wait_result("rec");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_llsc_ctrl.md
MEM_LLSC_CTRL -- requirements
Module: mem_llsc_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum BUSY cycles awaiting bus_ack_i before bus error (range 2..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 Rst_n  in  1  reset, synchronous, active-low.
REQ-004 flush  in  1  pipeline flush; abort current access.
REQ-005 op_i  in  3  000 none, 001 LW, 010 SW, 011 LL, 100 SC; others treated as none.
REQ-006 addr_i, wdata_i  in  32 each  access address, store data; wd_i  in  5  destination register.
REQ-007 LLbit_i  in  1  current LLbit register value.
REQ-008 wb_LLbit_we_i, wb_LLbit_value_i  in  1 each  pending LLbit write from write-back stage (forwarding).
REQ-009 bus_req_o, bus_we_o  out  1 each; bus_addr_o, bus_wdata_o  out  32 each; bus_rdata_i  in  32; bus_ack_i  in  1.
REQ-010 stall_o  out  1  pipeline hold request.
REQ-011 wreg_o  out  1; wd_o  out  5; wdata_o  out  32  register write-back result.
REQ-012 LLbit_we_o, LLbit_value_o  out  1 each  LLbit register write port.
REQ-013 excep_o  out  2  one-cycle pulse: 01 misaligned, 10 bus timeout, 00 none.

Function
REQ-014 States IDLE, BUSY, DONE; all outputs registered except stall_o.
REQ-015 Effective LLbit = wb_LLbit_value_i when wb_LLbit_we_i=1, else LLbit_i.
REQ-016 IDLE, valid op, addr_i[1:0]!=00: excep_o=01 next cycle, no bus access, no register/LLbit write, stay IDLE.
REQ-017 IDLE, valid aligned LW/SW/LL, or SC with effective LLbit=1: latch op/addr/data/wd, go BUSY; bus_req_o=1 from next cycle.
REQ-018 IDLE, SC with effective LLbit=0: no bus access, go DONE; result wdata_o=0, wreg_o=1, LLbit_we_o=0.
REQ-019 BUSY: bus_req_o held 1, bus_addr_o/bus_wdata_o/bus_we_o stable; bus_we_o=1 for SW/SC only.
REQ-020 BUSY and bus_ack_i=1: bus_req_o=0 next cycle, capture bus_rdata_i, go DONE.
REQ-021 BUSY cycle counter starts at 0 on entry; reaching TIMEOUT without ack: excep_o=10, bus_req_o=0, no writes, go IDLE.
REQ-022 DONE lasts exactly one cycle, then IDLE; wreg_o/LLbit_we_o are one-cycle pulses in DONE.
REQ-023 DONE results: LW wreg_o=1, wdata_o=rdata; LL wreg_o=1, wdata_o=rdata, LLbit_we_o=1, LLbit_value_o=1; SW wreg_o=0; successful SC wreg_o=1, wdata_o=1, LLbit_we_o=1, LLbit_value_o=0.
REQ-024 stall_o=1 combinationally when (IDLE and valid aligned op) or BUSY; 0 in DONE and otherwise.
REQ-025 flush=1 in any state: next state IDLE, bus_req_o=0, wreg_o=0, LLbit_we_o=0, excep_o=00; flush overrides ack and timeout in the same cycle.
REQ-026 bus_ack_i outside BUSY ignored.
REQ-027 wd_o equals latched wd_i during DONE; 0 otherwise.

Reset
REQ-028 Rst_n=0 at rising edge: state IDLE, counter 0, all registered outputs 0; stall_o=0 while reset asserted.
REQ-029 Reset mid-BUSY drops bus_req_o next cycle, discards access; Rst_n has priority over flush.

Verification
REQ-030 LW addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> bus_req_o 3 cycles, DONE wreg_o=1, wdata_o=0xDEADBEEF, stall_o drops in DONE.
REQ-031 LL 0x200 then SC 0x200 (LLbit_i=1, data 0x55) -> LL writes LLbit 1; SC bus_we_o=1, wdata_o=1, LLbit_we_o=1 value 0.
REQ-032 SC with LLbit_i=1 but wb_LLbit_we_i=1, value 0 -> no bus_req_o, wdata_o=0, one stall cycle.
REQ-033 SW addr 0x102 -> excep_o=01 one cycle, bus_req_o never asserted.
REQ-034 LW, ack never arrives, TIMEOUT=16 -> excep_o=10 after 16 BUSY cycles, no wreg_o.
REQ-035 flush (or Rst_n=0) on BUSY cycle 2 coincident with bus_ack_i -> IDLE, no wreg_o/LLbit_we_o pulse.
